// File: rtl/cnt_all_one_tc.sv
// rtl/cnt_all_one_tc.sv - up-counter with registered terminal count, wrap pulse and sticky overflow
// Priority per cycle: clear, then load, then increment, else hold.
module cnt_all_one_tc #(
    parameter int width = 8,
    parameter int SAT   = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [width-1:0] ld_val_i,
    input  logic             en_i,
    input  logic             ovf_clr_i,
    output logic [width-1:0] cnt_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             ovf_o
);

    logic [width-1:0] r_cnt;
    logic             r_tc;
    logic             r_wrap;
    logic             r_ovf;

    logic [width-1:0] w_cnt_nxt;
    logic             w_tc_nxt;
    logic             w_wrap_nxt;
    logic             w_ovf_nxt;

    // r_tc already marks the current count as all-ones, so no second detector is needed
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_wrap_nxt = 1'b0;
        w_ovf_nxt  = r_ovf & ~ovf_clr_i;
        if (clr_i) begin
            w_cnt_nxt = '0;
            w_ovf_nxt = 1'b0;
        end else if (ld_i) begin
            w_cnt_nxt = ld_val_i;
        end else if (en_i) begin
            if (r_tc) begin
                w_ovf_nxt = 1'b1;
                if (SAT == 0) begin
                    w_cnt_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                end
            end else begin
                w_cnt_nxt = r_cnt + width'(1);
            end
        end
    end

    assign w_tc_nxt = &w_cnt_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt  <= '0;
            r_tc   <= 1'b0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tc   <= w_tc_nxt;
            r_wrap <= w_wrap_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign cnt_o  = r_cnt;
    assign tc_o   = r_tc;
    assign wrap_o = r_wrap;
    assign ovf_o  = r_ovf;

endmodule
